// File: rtl/conv_window_ctrl_pkg.sv
// rtl/conv_window_ctrl_pkg.sv - shared defaults and width helpers for the window controller
package conv_window_ctrl_pkg;

    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_DATA_SIZE   = 8;
    localparam int DEF_ROW_SIZE    = 28;
    localparam int DEF_COL_SIZE    = 28;
    localparam int DEF_STRIDE      = 1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    // Width of a counter that runs 0..max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (clog2(max_val + 1) < 1) ? 1 : clog2(max_val + 1);
    endfunction

    function automatic int out_cnt_w(input int size, input int k, input int s);
        return cnt_w((size - k) / s);
    endfunction

endpackage

// File: rtl/conv_window_ctrl_raster_pos_counter.sv
// rtl/conv_window_ctrl_raster_pos_counter.sv - raster position, stride phase and output-map counters
module raster_pos_counter
    import conv_window_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int ROW_SIZE    = DEF_ROW_SIZE,
    parameter int COL_SIZE    = DEF_COL_SIZE,
    parameter int STRIDE      = DEF_STRIDE
) (
    input  logic                                                i_clock,
    input  logic                                                i_reset,
    input  logic                                                i_data_valid,
    output logic                                                o_accept,
    output logic                                                o_last_pixel,
    output logic [out_cnt_w(COL_SIZE, KERNEL_SIZE, STRIDE)-1:0] o_out_row,
    output logic [out_cnt_w(ROW_SIZE, KERNEL_SIZE, STRIDE)-1:0] o_out_col
);

    localparam int RW  = cnt_w(COL_SIZE - 1);
    localparam int CW  = cnt_w(ROW_SIZE - 1);
    localparam int PW  = cnt_w(STRIDE - 1);
    localparam int ORW = out_cnt_w(COL_SIZE, KERNEL_SIZE, STRIDE);
    localparam int OCW = out_cnt_w(ROW_SIZE, KERNEL_SIZE, STRIDE);

    localparam logic [RW-1:0] ROW_LAST      = RW'(COL_SIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] COL_LAST      = CW'(ROW_SIZE - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KERNEL_SIZE - 1);
    localparam logic [PW-1:0] PH_LAST       = PW'(STRIDE - 1);

    logic [RW-1:0]  r_row;
    logic [CW-1:0]  r_col;
    logic [PW-1:0]  r_row_ph;
    logic [PW-1:0]  r_col_ph;
    logic [ORW-1:0] r_orow;
    logic [OCW-1:0] r_ocol;
    logic           r_row_hit;
    logic           r_any_row;

    logic           w_row_end;
    logic           w_frame_end;
    logic           w_accept;
    logic [ORW-1:0] w_orow_cur;
    logic [OCW-1:0] w_ocol_cur;

    assign w_row_end   = (r_col == COL_LAST);
    assign w_frame_end = w_row_end && (r_row == ROW_LAST);
    assign w_accept    = i_data_valid && (r_row >= ROW_FIRST_WIN) && (r_col >= COL_FIRST_WIN)
                         && (r_row_ph == '0) && (r_col_ph == '0);

    // The output row advances on the first accept of every accepted row after the first,
    // so the counter never runs past OH-1 even when trailing rows are off the stride grid.
    assign w_orow_cur = (r_any_row && !r_row_hit) ? r_orow + 1'b1 : r_orow;
    assign w_ocol_cur = r_row_hit ? r_ocol + 1'b1 : '0;

    assign o_accept     = w_accept;
    assign o_last_pixel = i_data_valid && w_frame_end;
    assign o_out_row    = w_orow_cur;
    assign o_out_col    = w_ocol_cur;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_row     <= '0;
            r_col     <= '0;
            r_row_ph  <= '0;
            r_col_ph  <= '0;
            r_orow    <= '0;
            r_ocol    <= '0;
            r_row_hit <= 1'b0;
            r_any_row <= 1'b0;
        end else if (i_data_valid) begin
            if (w_accept) begin
                r_orow    <= w_orow_cur;
                r_ocol    <= w_ocol_cur;
                r_row_hit <= 1'b1;
                r_any_row <= 1'b1;
            end
            if (w_frame_end) begin
                r_row     <= '0;
                r_col     <= '0;
                r_row_ph  <= '0;
                r_col_ph  <= '0;
                r_orow    <= '0;
                r_ocol    <= '0;
                r_row_hit <= 1'b0;
                r_any_row <= 1'b0;
            end else if (w_row_end) begin
                r_col     <= '0;
                r_col_ph  <= '0;
                r_row     <= r_row + 1'b1;
                r_row_ph  <= (r_row < ROW_FIRST_WIN || r_row_ph == PH_LAST) ? '0 : r_row_ph + 1'b1;
                r_row_hit <= 1'b0;
                r_ocol    <= '0;
            end else begin
                r_col     <= r_col + 1'b1;
                r_col_ph  <= (r_col < COL_FIRST_WIN || r_col_ph == PH_LAST) ? '0 : r_col_ph + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - registers the KxK window, valid strobe and coordinates for the MAC array
module conv_window_ctrl
    import conv_window_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int ROW_SIZE    = DEF_ROW_SIZE,
    parameter int COL_SIZE    = DEF_COL_SIZE,
    parameter int STRIDE      = DEF_STRIDE
) (
    input  logic                                                i_clock,
    input  logic                                                i_reset,
    input  logic                                                i_data_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0]        i_rows_in,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0]        o_window_out,
    output logic                                                o_window_valid,
    output logic [out_cnt_w(COL_SIZE, KERNEL_SIZE, STRIDE)-1:0] o_out_row,
    output logic [out_cnt_w(ROW_SIZE, KERNEL_SIZE, STRIDE)-1:0] o_out_col,
    output logic                                                o_frame_done
);

    localparam int WIN_W = KERNEL_SIZE * KERNEL_SIZE * DATA_SIZE;
    localparam int ORW   = out_cnt_w(COL_SIZE, KERNEL_SIZE, STRIDE);
    localparam int OCW   = out_cnt_w(ROW_SIZE, KERNEL_SIZE, STRIDE);

    logic             w_accept;
    logic             w_last_pixel;
    logic [ORW-1:0]   w_out_row;
    logic [OCW-1:0]   w_out_col;

    logic [WIN_W-1:0] r_window;
    logic             r_valid;
    logic [ORW-1:0]   r_out_row;
    logic [OCW-1:0]   r_out_col;
    logic             r_frame_done;

    raster_pos_counter #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .ROW_SIZE    (ROW_SIZE),
        .COL_SIZE    (COL_SIZE),
        .STRIDE      (STRIDE)
    ) u_pos (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_data_valid (i_data_valid),
        .o_accept     (w_accept),
        .o_last_pixel (w_last_pixel),
        .o_out_row    (w_out_row),
        .o_out_col    (w_out_col)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_window     <= '0;
            r_valid      <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= w_accept;
            r_frame_done <= w_last_pixel;
            if (w_accept) begin
                r_window  <= i_rows_in;
                r_out_row <= w_out_row;
                r_out_col <= w_out_col;
            end
        end
    end

    assign o_window_out   = r_window;
    assign o_window_valid = r_valid;
    assign o_out_row      = r_out_row;
    assign o_out_col      = r_out_col;
    assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb/tb_conv_window_ctrl.sv - scoreboard bench for conv_window_ctrl (stride 1, stride 2, 3x3 image)
module tb_conv_window_ctrl;

    localparam int K  = 3;
    localparam int WB = 72;
    localparam int NPIX = 784;
    localparam int P_W [3] = '{28, 28, 3};
    localparam int P_H [3] = '{28, 28, 3};
    localparam int P_S [3] = '{1, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          dv;
    logic [WB-1:0] rows;

    logic [WB-1:0] win0, win1, win2;
    logic          vld0, vld1, vld2;
    logic          fd0, fd1, fd2;
    logic [4:0]    row0, col0;
    logic [3:0]    row1, col1;
    logic          row2, col2;

    conv_window_ctrl u_s1 (
        .i_clock(clk), .i_reset(rst), .i_data_valid(dv), .i_rows_in(rows),
        .o_window_out(win0), .o_window_valid(vld0), .o_out_row(row0), .o_out_col(col0),
        .o_frame_done(fd0)
    );

    conv_window_ctrl #(.STRIDE(2)) u_s2 (
        .i_clock(clk), .i_reset(rst), .i_data_valid(dv), .i_rows_in(rows),
        .o_window_out(win1), .o_window_valid(vld1), .o_out_row(row1), .o_out_col(col1),
        .o_frame_done(fd1)
    );

    conv_window_ctrl #(.ROW_SIZE(3), .COL_SIZE(3)) u_k3 (
        .i_clock(clk), .i_reset(rst), .i_data_valid(dv), .i_rows_in(rows),
        .o_window_out(win2), .o_window_valid(vld2), .o_out_row(row2), .o_out_col(col2),
        .o_frame_done(fd2)
    );

    logic [WB-1:0] a_win [3];
    logic          a_vld [3];
    logic          a_fd  [3];
    logic [31:0]   a_row [3];
    logic [31:0]   a_col [3];

    assign a_win[0] = win0;  assign a_win[1] = win1;  assign a_win[2] = win2;
    assign a_vld[0] = vld0;  assign a_vld[1] = vld1;  assign a_vld[2] = vld2;
    assign a_fd[0]  = fd0;   assign a_fd[1]  = fd1;   assign a_fd[2]  = fd2;
    assign a_row[0] = 32'(row0); assign a_row[1] = 32'(row1); assign a_row[2] = 32'(row2);
    assign a_col[0] = 32'(col0); assign a_col[1] = 32'(col1); assign a_col[2] = 32'(col2);

    typedef struct {
        logic [WB-1:0] win;
        int            orow;
        int            ocol;
    } exp_t;

    typedef struct {
        string name;
        int    gap_every;
        int    n_frames;
        int    exp_s1;
        int    exp_s2;
        int    exp_k3;
        int    exp_fd0;
        int    exp_fd2;
    } vec_t;

    exp_t sbq [3][$];
    int   m_r [3];
    int   m_c [3];
    bit   v_exp [3];
    bit   fd_exp [3];
    int   strobes [3];
    int   fdones [3];
    int   pix, drv_pix, first_pix, last_row0, last_col0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [3];

    task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            m_r[i] = 0; m_c[i] = 0; v_exp[i] = 0; fd_exp[i] = 0;
            strobes[i] = 0; fdones[i] = 0;
            sbq[i].delete();
        end
        pix = 0; drv_pix = 0; first_pix = -1; last_row0 = -1; last_col0 = -1;
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_win[%0d]", tag, i), a_win[i], '0);
            chk($sformatf("%s_vld[%0d]", tag, i), a_vld[i], '0);
            chk($sformatf("%s_row[%0d]", tag, i), a_row[i], '0);
            chk($sformatf("%s_col[%0d]", tag, i), a_col[i], '0);
            chk($sformatf("%s_fd[%0d]", tag, i), a_fd[i], '0);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid[%0d] pix%0d", i, drv_pix), a_vld[i], v_exp[i]);
            chk($sformatf("frame_done[%0d] pix%0d", i, drv_pix), a_fd[i], fd_exp[i]);
            if (v_exp[i]) begin
                e = sbq[i].pop_front();
                if (a_vld[i]) begin
                    chk($sformatf("window[%0d]", i), a_win[i], e.win);
                    chk($sformatf("out_row[%0d]", i), a_row[i], e.orow);
                    chk($sformatf("out_col[%0d]", i), a_col[i], e.ocol);
                end
            end
            if (a_vld[i]) begin
                strobes[i]++;
                if (i == 0) begin
                    if (first_pix < 0) first_pix = drv_pix;
                    last_row0 = int'(a_row[0]);
                    last_col0 = int'(a_col[0]);
                end
            end
            if (a_fd[i]) fdones[i]++;
        end
    endtask

    task automatic drive(input bit v);
        bit acc;
        int rr, cc;
        @(negedge clk);
        rows = {$urandom(), $urandom(), 8'($urandom())};
        dv   = v;
        for (int i = 0; i < 3; i++) begin
            v_exp[i]  = 0;
            fd_exp[i] = 0;
            if (v) begin
                rr  = m_r[i];
                cc  = m_c[i];
                acc = (rr >= K - 1) && (cc >= K - 1) &&
                      ((rr - K + 1) % P_S[i] == 0) && ((cc - K + 1) % P_S[i] == 0);
                if (acc) sbq[i].push_back('{win: rows, orow: (rr - K + 1) / P_S[i],
                                            ocol: (cc - K + 1) / P_S[i]});
                v_exp[i]  = acc;
                fd_exp[i] = (rr == P_H[i] - 1) && (cc == P_W[i] - 1);
                if (cc == P_W[i] - 1) begin
                    m_c[i] = 0;
                    m_r[i] = (rr == P_H[i] - 1) ? 0 : rr + 1;
                end else begin
                    m_c[i] = cc + 1;
                end
            end
        end
        if (v) begin
            drv_pix = pix;
            pix++;
        end
        @(posedge clk);
        #1 check_outputs();
    endtask

    // Reset is raised between clock edges so the zeroed outputs prove the asynchronous path.
    task automatic reset_mid(input string tag);
        #2 rst = 1'b1;
        dv = 1'b0;
        #1 check_zero(tag);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic run_pixels(input int n, input int gap_every);
        for (int p = 0; p < n; p++) begin
            drive(1'b1);
            if (gap_every > 0 && (p % gap_every) == gap_every - 1) repeat (3) drive(1'b0);
        end
        repeat (2) drive(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{name: "back2back",  gap_every: 0, n_frames: 1, exp_s1: 676,  exp_s2: 169,
                    exp_k3: 87,  exp_fd0: 1, exp_fd2: 87};
        vecs[1] = '{name: "gaps",       gap_every: 5, n_frames: 1, exp_s1: 676,  exp_s2: 169,
                    exp_k3: 87,  exp_fd0: 1, exp_fd2: 87};
        vecs[2] = '{name: "two_frames", gap_every: 0, n_frames: 2, exp_s1: 1352, exp_s2: 338,
                    exp_k3: 174, exp_fd0: 2, exp_fd2: 174};

        rst  = 1'b1;
        dv   = 1'b0;
        rows = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            if (t > 0) reset_mid($sformatf("rst_%s", vecs[t].name));
            run_pixels(vecs[t].n_frames * NPIX, vecs[t].gap_every);
            chk({vecs[t].name, "_strobes_s1"}, strobes[0], vecs[t].exp_s1);
            chk({vecs[t].name, "_strobes_s2"}, strobes[1], vecs[t].exp_s2);
            chk({vecs[t].name, "_strobes_k3"}, strobes[2], vecs[t].exp_k3);
            chk({vecs[t].name, "_fdone_s1"}, fdones[0], vecs[t].exp_fd0);
            chk({vecs[t].name, "_fdone_s2"}, fdones[1], vecs[t].exp_fd0);
            chk({vecs[t].name, "_fdone_k3"}, fdones[2], vecs[t].exp_fd2);
            chk({vecs[t].name, "_first_pix"}, first_pix, 58);
            chk({vecs[t].name, "_last_row"}, last_row0, 25);
            chk({vecs[t].name, "_last_col"}, last_col0, 25);
            chk({vecs[t].name, "_sb_empty"}, sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
        end

        reset_mid("rst_pre");
        for (int p = 0; p < 300; p++) drive(1'b1);
        reset_mid("rst_at300");
        run_pixels(NPIX, 0);
        chk("restart_strobes_s1", strobes[0], 676);
        chk("restart_strobes_s2", strobes[1], 169);
        chk("restart_fdone_s1", fdones[0], 1);
        chk("restart_first_pix", first_pix, 58);
        chk("restart_last_row", last_row0, 25);
        chk("restart_last_col", last_col0, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
